// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer and the ALU datapath:
// MIPS opcode/funct constants, 3-bit ALU operation codes and the sequencer state enum.
package alu_pkg;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_MOVZ = 6'b001010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_MOVZ = 3'b110,
        ALU_SLL  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_RTYPE = 2'd1,
        CLS_BEQ   = 2'd2
    } instr_cls_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: maps a MIPS word to ALU op, shift amount,
// instruction class and a legal flag. The halt opcode is handled by the sequencer.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_e     alu_op,
    output logic [4:0]  alu_sa,
    output instr_cls_e  cls,
    output logic        legal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    // register specifiers are not needed for sequencing
    assign unused_fields = ^instr[25:11];

    always_comb begin
        alu_op = ALU_ADD;
        alu_sa = 5'd0;
        cls    = CLS_NONE;
        legal  = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                cls   = CLS_RTYPE;
                legal = 1'b1;
                case (funct)
                    FUNCT_ADD:  alu_op = ALU_ADD;
                    FUNCT_SUB:  alu_op = ALU_SUB;
                    FUNCT_AND:  alu_op = ALU_AND;
                    FUNCT_OR:   alu_op = ALU_OR;
                    FUNCT_XOR:  alu_op = ALU_XOR;
                    FUNCT_SLT:  alu_op = ALU_SLT;
                    FUNCT_MOVZ: alu_op = ALU_MOVZ;
                    FUNCT_SLL: begin
                        alu_op = ALU_SLL;
                        alu_sa = instr[10:6];
                    end
                    default: begin
                        cls   = CLS_NONE;
                        legal = 1'b0;
                    end
                endcase
            end
            OPC_BEQ: begin
                alu_op = ALU_SUB;
                cls    = CLS_BEQ;
                legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU instruction sequencer (IDLE -> DECODE -> EXEC -> WB, one instruction per 4 cycles).
// Optional retired-instruction counter enabled by defining ALU_SEQ_STATS_EN.
//
// state  | meaning
// IDLE   | instr_ready high, waiting for instr_valid
// DECODE | decode registered instr; illegal -> IDLE, halt opcode -> HALT
// EXEC   | alu_en high, sample rt_zero / alu_zero
// WB     | reg_we / branch_taken strobes, back to IDLE
// HALT   | halt high, ignores everything until reset
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [5:0] HALT_OPC = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        rt_zero,
    input  logic        alu_zero,
    output logic [2:0]  alu_op,
    output logic [4:0]  alu_sa,
    output logic        alu_en,
    output logic        reg_we,
    output logic        branch_taken,
    output logic        illegal,
    output logic        halt
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    state_e     state, next_state;
    logic [31:0] instr_q;
    alu_op_e    alu_op_q;
    logic [4:0] alu_sa_q;
    instr_cls_e cls_q;
    logic       ready_q;
    logic       write_q;
    logic       branch_q;

    alu_op_e    dec_op;
    logic [4:0] dec_sa;
    instr_cls_e dec_cls;
    logic       dec_legal;
    logic       is_halt;
    logic       accept;

    alu_decode u_decode (
        .instr  (instr_q),
        .alu_op (dec_op),
        .alu_sa (dec_sa),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    assign is_halt = (instr_q[31:26] == HALT_OPC);
    assign accept  = instr_valid && ready_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_DECODE;
            ST_DECODE: begin
                // halt takes precedence so HALT_OPC may alias any opcode
                if (is_halt)         next_state = ST_HALT;
                else if (!dec_legal) next_state = ST_IDLE;
                else                 next_state = ST_EXEC;
            end
            ST_EXEC:   next_state = ST_WB;
            ST_WB:     next_state = ST_IDLE;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            instr_q  <= 32'd0;
            alu_op_q <= ALU_ADD;
            alu_sa_q <= 5'd0;
            cls_q    <= CLS_NONE;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            state   <= next_state;
            // ready stays low for the first cycle after reset release
            ready_q <= (next_state == ST_IDLE);
            if (state == ST_IDLE && accept) begin
                instr_q <= instr;
            end
            if (state == ST_DECODE && dec_legal && !is_halt) begin
                alu_op_q <= dec_op;
                alu_sa_q <= dec_sa;
                cls_q    <= dec_cls;
            end
            if (state == ST_EXEC) begin
                write_q  <= (cls_q == CLS_RTYPE) && !(alu_op_q == ALU_MOVZ && !rt_zero);
                branch_q <= (cls_q == CLS_BEQ) && alu_zero;
            end
        end
    end

    assign instr_ready  = ready_q;
    assign alu_op       = alu_op_q;
    assign alu_sa       = alu_sa_q;
    assign alu_en       = (state == ST_EXEC);
    assign reg_we       = (state == ST_WB) && write_q;
    assign branch_taken = (state == ST_WB) && branch_q;
    assign illegal      = (state == ST_DECODE) && !is_halt && !dec_legal;
    assign halt         = (state == ST_HALT);

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
        end else if (state == ST_WB) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; inputs driven and outputs sampled on negedge.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_ready;
    logic        rt_zero = 1'b0;
    logic        alu_zero = 1'b0;
    logic [2:0]  alu_op;
    logic [4:0]  alu_sa;
    logic        alu_en;
    logic        reg_we;
    logic        branch_taken;
    logic        illegal;
    logic        halt;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .rt_zero      (rt_zero),
        .alu_zero     (alu_zero),
        .alu_op       (alu_op),
        .alu_sa       (alu_sa),
        .alu_en       (alu_en),
        .reg_we       (reg_we),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .halt         (halt)
`ifdef ALU_SEQ_STATS_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    // Offers ins, waits (bounded) for acceptance and returns at the negedge of the DECODE cycle.
    task automatic issue(input logic [31:0] ins, input bit hold);
        int n;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout instr=%h ready=%b expected 1", ins, instr_ready);
        end
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready, alu_op, alu_sa, alu_en, reg_we, branch_taken, illegal, halt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected 0", {instr_ready, alu_op, alu_sa, alu_en, reg_we, branch_taken, illegal, halt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || alu_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b alu_en=%b expected 1 0", instr_ready, alu_en);
        end
    endtask

    task automatic test_add_held();
        rt_zero = 1'b0;
        issue(32'h00221820, 1'b1);
        checks++;
        if (instr_ready !== 1'b0 || alu_en !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL add_decode ready=%b alu_en=%b reg_we=%b expected 0 0 0", instr_ready, alu_en, reg_we);
        end
        @(negedge clk);
        checks++;
        if (alu_en !== 1'b1 || alu_op !== 3'b000 || reg_we !== 1'b0 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec alu_en=%b alu_op=%b reg_we=%b ready=%b expected 1 000 0 0", alu_en, alu_op, reg_we, instr_ready);
        end
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b1 || alu_en !== 1'b0 || branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL add_wb reg_we=%b alu_en=%b branch=%b expected 1 0 0", reg_we, alu_en, branch_taken);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_idle reg_we=%b ready=%b expected 0 1", reg_we, instr_ready);
        end
    endtask

    task automatic test_r_ops();
        logic [31:0] ins [7]  = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
                                  32'h00221826, 32'h0022182A, 32'h00221960};
        logic [2:0]  ops [7]  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
        rt_zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue(ins[i], 1'b0);
            @(negedge clk);
            checks++;
            if (alu_en !== 1'b1 || alu_op !== ops[i] || alu_sa !== 5'd0) begin
                errors++;
                $display("FAIL rop_exec[%0d] alu_en=%b op=%b sa=%0d expected 1 %b 0", i, alu_en, alu_op, alu_sa, ops[i]);
            end
            @(negedge clk);
            checks++;
            if (reg_we !== 1'b1 || alu_op !== ops[i]) begin
                errors++;
                $display("FAIL rop_wb[%0d] reg_we=%b op=%b expected 1 %b", i, reg_we, alu_op, ops[i]);
            end
        end
    endtask

    task automatic test_sll();
        issue(32'h00021100, 1'b0);
        @(negedge clk);
        checks++;
        if (alu_op !== 3'b111 || alu_sa !== 5'd4 || alu_en !== 1'b1) begin
            errors++;
            $display("FAIL sll_exec op=%b sa=%0d en=%b expected 111 4 1", alu_op, alu_sa, alu_en);
        end
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b1 || alu_sa !== 5'd4) begin
            errors++;
            $display("FAIL sll_wb reg_we=%b sa=%0d expected 1 4", reg_we, alu_sa);
        end
    endtask

    task automatic test_movz();
        rt_zero = 1'b0;
        issue(32'h0022180A, 1'b0);
        @(negedge clk);
        checks++;
        if (alu_op !== 3'b110 || alu_sa !== 5'd0) begin
            errors++;
            $display("FAIL movz_exec op=%b sa=%0d expected 110 0", alu_op, alu_sa);
        end
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL movz_nz_wb reg_we=%b expected 0", reg_we);
        end
        rt_zero = 1'b1;
        issue(32'h0022180A, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b1) begin
            errors++;
            $display("FAIL movz_z_wb reg_we=%b expected 1", reg_we);
        end
        rt_zero = 1'b0;
    endtask

    task automatic test_beq();
        alu_zero = 1'b1;
        issue(32'h10220003, 1'b0);
        @(negedge clk);
        checks++;
        if (alu_op !== 3'b001 || alu_en !== 1'b1) begin
            errors++;
            $display("FAIL beq_exec op=%b en=%b expected 001 1", alu_op, alu_en);
        end
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b1 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL beq_taken_wb branch=%b reg_we=%b expected 1 0", branch_taken, reg_we);
        end
        alu_zero = 1'b0;
        issue(32'h10220003, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_wb branch=%b reg_we=%b expected 0 0", branch_taken, reg_we);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2] = '{32'h0000003F, 32'h20000000};
        for (int i = 0; i < 2; i++) begin
            issue(ins[i], 1'b0);
            checks++;
            if (illegal !== 1'b1 || alu_en !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse[%0d] illegal=%b en=%b expected 1 0", i, illegal, alu_en);
            end
            @(negedge clk);
            checks++;
            if (illegal !== 1'b0 || instr_ready !== 1'b1 || alu_en !== 1'b0 || reg_we !== 1'b0) begin
                errors++;
                $display("FAIL illegal_idle[%0d] illegal=%b ready=%b en=%b we=%b expected 0 1 0 0", i, illegal, instr_ready, alu_en, reg_we);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen_we;
        issue(32'h00021100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_ready, alu_op, alu_sa, alu_en, reg_we, branch_taken, illegal, halt} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b expected 0", {instr_ready, alu_op, alu_sa, alu_en, reg_we, branch_taken, illegal, halt});
        end
        seen_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (reg_we || branch_taken) seen_we = 1'b1;
        end
        checks++;
        if (seen_we !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_discard strobe_seen=%b ready=%b expected 0 1", seen_we, instr_ready);
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        logic [31:0] ins [6] = '{32'h00221820, 32'h0000003F, 32'h00021100, 32'h10220003,
                                 32'h00221822, 32'h0022182A};
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset got=%0d expected 0", retired_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) issue(ins[i], 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (retired_cnt !== 32'd5) begin
            errors++;
            $display("FAIL stats_count got=%0d expected 5", retired_cnt);
        end
    endtask
`endif

    task automatic test_halt();
        int bad;
        issue(32'hFC000000, 1'b1);
        @(negedge clk);
        checks++;
        if (halt !== 1'b1 || instr_ready !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter halt=%b ready=%b illegal=%b expected 1 0 0", halt, instr_ready, illegal);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (halt !== 1'b1 || instr_ready !== 1'b0 || alu_en !== 1'b0 || reg_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold bad_cycles=%0d expected 0", bad);
        end
`ifdef ALU_SEQ_STATS_EN
        checks++;
        if (retired_cnt !== 32'd5) begin
            errors++;
            $display("FAIL halt_stats got=%0d expected 5", retired_cnt);
        end
`endif
        instr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_held();
        test_r_ops();
        test_sll();
        test_movz();
        test_beq();
        test_illegal();
        test_mid_reset();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
